// File: rtl/trap_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : trap_seq_if
//  Description : Bundle of IDU/LSU request, CSR port and IFU redirect signals
//                shared by the trap sequencer and its surroundings.
//  Revision    : 1.0  initial release
// ============================================================================
interface trap_seq_if;
    logic        i_ecall;
    logic        i_mret;
    logic [31:0] i_pc;
    logic [31:0] i_cause;
    logic        i_lsu_busy;
    logic        o_csr_wen;
    logic [11:0] o_csr_wid;
    logic [31:0] o_csr_wdata;
    logic        o_csr_ren;
    logic [11:0] o_csr_rid;
    logic [31:0] i_csr_rdata;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;
    logic        o_stall;
    logic        o_busy;
    logic        o_drain_err;

    // Sequencer side
    modport master (
        input  i_ecall, i_mret, i_pc, i_cause, i_lsu_busy, i_csr_rdata,
        output o_csr_wen, o_csr_wid, o_csr_wdata, o_csr_ren, o_csr_rid,
        output o_redirect_valid, o_redirect_pc, o_stall, o_busy, o_drain_err
    );

    // IDU / LSU / CSR controller / IFU side
    modport slave (
        output i_ecall, i_mret, i_pc, i_cause, i_lsu_busy, i_csr_rdata,
        input  o_csr_wen, o_csr_wid, o_csr_wdata, o_csr_ren, o_csr_rid,
        input  o_redirect_valid, o_redirect_pc, o_stall, o_busy, o_drain_err
    );
endinterface
`default_nettype wire

// File: rtl/trap_seq.sv
`default_nettype none
// ============================================================================
//  Module      : trap_seq
//  Description : Multi-cycle ecall/mret sequencer. Stalls the front end,
//                drains outstanding LSU traffic, updates mepc/mcause/mstatus
//                one CSR write per cycle and issues a one-cycle PC redirect.
//  Revision    : 1.0  initial release
// ============================================================================
module trap_seq #(
    parameter int DRAIN_TIMEOUT = 255
) (
    input  wire logic   clk,
    input  wire logic   rst,
    trap_seq_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAIN   = 3'd1,
        S_W_EPC   = 3'd2,
        S_W_CAUSE = 3'd3,
        S_W_STAT  = 3'd4,
        S_REDIR   = 3'd5
    } state_t;

    localparam logic [11:0] c_CSR_MSTATUS = 12'h300;
    localparam logic [11:0] c_CSR_MTVEC   = 12'h305;
    localparam logic [11:0] c_CSR_MEPC    = 12'h341;
    localparam logic [11:0] c_CSR_MCAUSE  = 12'h342;
    localparam logic [31:0] c_ALIGN_MASK  = 32'hFFFF_FFFC;
    localparam logic [8:0]  c_DRAIN_LIMIT = 9'(DRAIN_TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_kind_ecall;
    logic [31:0] r_pc;
    logic [31:0] r_cause;
    logic [7:0]  r_drain_cnt;
    logic [8:0]  w_drain_cnt_inc;
    logic        w_drain_timeout;
    logic        w_req;

    assign w_req           = bus.i_ecall | bus.i_mret;
    // Count including the current busy cycle, so the limit is hit on the
    // DRAIN_TIMEOUT-th cycle spent waiting.
    assign w_drain_cnt_inc = {1'b0, r_drain_cnt} + 9'd1;
    assign w_drain_timeout = bus.i_lsu_busy && (w_drain_cnt_inc >= c_DRAIN_LIMIT);

    // State register, request latches and drain counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_kind_ecall <= 1'b0;
            r_pc         <= 32'h0;
            r_cause      <= 32'h0;
            r_drain_cnt  <= 8'h0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_req) begin
                r_kind_ecall <= bus.i_ecall;
                if (bus.i_ecall) begin
                    r_pc    <= bus.i_pc;
                    r_cause <= bus.i_cause;
                end
            end
            if (r_state != S_DRAIN) begin
                r_drain_cnt <= 8'h0;
            end else if (bus.i_lsu_busy) begin
                r_drain_cnt <= r_drain_cnt + 8'd1;
            end
        end
    end

    // Next-state decode and per-state CSR / redirect outputs
    always_comb begin
        w_state_nxt          = r_state;
        bus.o_csr_wen        = 1'b0;
        bus.o_csr_wid        = 12'h0;
        bus.o_csr_wdata      = 32'h0;
        bus.o_csr_ren        = 1'b0;
        bus.o_csr_rid        = 12'h0;
        bus.o_redirect_valid = 1'b0;
        bus.o_redirect_pc    = 32'h0;
        bus.o_drain_err      = 1'b0;
        bus.o_stall          = 1'b1;
        bus.o_busy           = 1'b1;
        case (r_state)
            S_IDLE: begin
                // Stall already in the accept cycle so IDU holds the trap
                bus.o_busy  = 1'b0;
                bus.o_stall = w_req;
                if (w_req) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!bus.i_lsu_busy || w_drain_timeout) begin
                    bus.o_drain_err = w_drain_timeout;
                    w_state_nxt     = r_kind_ecall ? S_W_EPC : S_W_STAT;
                end
            end
            S_W_EPC: begin
                bus.o_csr_wen   = 1'b1;
                bus.o_csr_wid   = c_CSR_MEPC;
                bus.o_csr_wdata = r_pc & c_ALIGN_MASK;
                w_state_nxt     = S_W_CAUSE;
            end
            S_W_CAUSE: begin
                bus.o_csr_wen   = 1'b1;
                bus.o_csr_wid   = c_CSR_MCAUSE;
                bus.o_csr_wdata = r_cause;
                w_state_nxt     = S_W_STAT;
            end
            S_W_STAT: begin
                // Read-modify-write of mstatus in a single cycle
                bus.o_csr_ren   = 1'b1;
                bus.o_csr_rid   = c_CSR_MSTATUS;
                bus.o_csr_wen   = 1'b1;
                bus.o_csr_wid   = c_CSR_MSTATUS;
                bus.o_csr_wdata = bus.i_csr_rdata;
                bus.o_csr_wdata[12:11] = 2'b11;
                if (r_kind_ecall) begin
                    bus.o_csr_wdata[7] = bus.i_csr_rdata[3];
                    bus.o_csr_wdata[3] = 1'b0;
                end else begin
                    bus.o_csr_wdata[3] = bus.i_csr_rdata[7];
                    bus.o_csr_wdata[7] = 1'b1;
                end
                w_state_nxt = S_REDIR;
            end
            S_REDIR: begin
                // Target comes straight from mtvec (ecall) or mepc (mret)
                bus.o_csr_ren        = 1'b1;
                bus.o_csr_rid        = r_kind_ecall ? c_CSR_MTVEC : c_CSR_MEPC;
                bus.o_redirect_valid = 1'b1;
                bus.o_redirect_pc    = bus.i_csr_rdata & c_ALIGN_MASK;
                w_state_nxt          = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_seq
//  Description : Self-checking bench for trap_seq: directed and randomized
//                ecall/mret sequences against a cycle-indexed reference model,
//                with a small CSR file model acting as the CSR controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trap_seq;

    localparam int TO = 8;

    typedef struct packed {
        logic        stall;
        logic        busy;
        logic        wen;
        logic [11:0] wid;
        logic [31:0] wdata;
        logic        ren;
        logic [11:0] rid;
        logic        rv;
        logic        err;
    } obs_t;

    logic clk;
    logic rst;
    logic ld;
    logic [31:0] ld_mtvec, ld_mepc, ld_mstatus;
    logic [31:0] env_mtvec, env_mepc, env_mcause, env_mstatus;
    int n_vec = 0;
    int n_bad = 0;

    trap_seq_if bus();

    trap_seq #(.DRAIN_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR controller model: plain register file with combinational read
    always @(posedge clk) begin
        if (ld) begin
            env_mtvec   <= ld_mtvec;
            env_mepc    <= ld_mepc;
            env_mstatus <= ld_mstatus;
            env_mcause  <= 32'h0;
        end else if (bus.o_csr_wen) begin
            case (bus.o_csr_wid)
                12'h305: env_mtvec   <= bus.o_csr_wdata;
                12'h341: env_mepc    <= bus.o_csr_wdata;
                12'h342: env_mcause  <= bus.o_csr_wdata;
                12'h300: env_mstatus <= bus.o_csr_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.i_csr_rdata = 32'h0;
        if (bus.o_csr_ren) begin
            case (bus.o_csr_rid)
                12'h305: bus.i_csr_rdata = env_mtvec;
                12'h341: bus.i_csr_rdata = env_mepc;
                12'h342: bus.i_csr_rdata = env_mcause;
                12'h300: bus.i_csr_rdata = env_mstatus;
                default: bus.i_csr_rdata = 32'h0;
            endcase
        end
    end

    function automatic obs_t sample();
        obs_t o;
        o.stall = bus.o_stall;
        o.busy  = bus.o_busy;
        o.wen   = bus.o_csr_wen;
        o.wid   = bus.o_csr_wid;
        o.wdata = bus.o_csr_wdata;
        o.ren   = bus.o_csr_ren;
        o.rid   = bus.o_csr_rid;
        o.rv    = bus.o_redirect_valid;
        o.err   = bus.o_drain_err;
        return o;
    endfunction

    // Architectural mstatus effect of taking a trap / returning from one
    function automatic logic [31:0] ecall_status(input logic [31:0] m);
        return (m & ~32'h0000_1888) | 32'h0000_1800 | (((m >> 3) & 32'h1) << 7);
    endfunction

    function automatic logic [31:0] mret_status(input logic [31:0] m);
        return (m & ~32'h0000_1888) | 32'h0000_1880 | (((m >> 7) & 32'h1) << 3);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One request from accept to the idle cycle after redirect (or to the
    // cycle after a reset asserted at cycle rst_at).
    task automatic run_txn(input string tag, input bit is_ecall, input bit both,
                           input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] mtvec, input logic [31:0] mepc,
                           input logic [31:0] mstatus, input int busy_len,
                           input bit noise, input int rst_at);
        obs_t        e;
        int          d, last, stop, s;
        bit          tmo;
        logic [31:0] rpc;
        tmo  = (busy_len >= TO);
        d    = tmo ? TO : busy_len + 1;
        last = d + (is_ecall ? 4 : 2);
        stop = (rst_at >= 0) ? rst_at + 1 : last + 1;
        rpc  = (is_ecall ? mtvec : mepc) & 32'hFFFF_FFFC;

        @(negedge clk);
        rst         = 1'b0;
        ld          = 1'b1;
        ld_mtvec    = mtvec;
        ld_mepc     = mepc;
        ld_mstatus  = mstatus;
        bus.i_ecall = 1'b0;
        bus.i_mret  = 1'b0;
        bus.i_lsu_busy = 1'($urandom_range(0, 1));
        bus.i_pc    = $urandom;
        bus.i_cause = $urandom;
        #1 check({tag, " idle"}, 64'(sample()), 64'h0);

        for (int k = 0; k <= stop; k++) begin
            @(negedge clk);
            ld  = 1'b0;
            rst = (rst_at >= 0) && (k >= rst_at);
            if (k == 0) begin
                bus.i_ecall = is_ecall;
                bus.i_mret  = !is_ecall || both;
                bus.i_pc    = pc;
                bus.i_cause = cause;
            end else if (k < stop) begin
                bus.i_ecall = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.i_mret  = noise;
                bus.i_pc    = $urandom;
                bus.i_cause = $urandom;
            end else begin
                bus.i_ecall = 1'b0;
                bus.i_mret  = 1'b0;
            end
            if (k >= 1 && k <= d) bus.i_lsu_busy = (k <= busy_len);
            else                  bus.i_lsu_busy = 1'($urandom_range(0, 1));

            e = '0;
            if (k < stop) begin
                e.stall = 1'b1;
                e.busy  = (k > 0);
                if (k >= 1 && k <= d) begin
                    e.err = tmo && (k == d);
                end else if (k > d) begin
                    s = k - d;
                    if (is_ecall) begin
                        case (s)
                            1: begin e.wen = 1'b1; e.wid = 12'h341; e.wdata = pc & 32'hFFFF_FFFC; end
                            2: begin e.wen = 1'b1; e.wid = 12'h342; e.wdata = cause; end
                            3: begin e.wen = 1'b1; e.wid = 12'h300; e.wdata = ecall_status(mstatus);
                                     e.ren = 1'b1; e.rid = 12'h300; end
                            default: begin e.ren = 1'b1; e.rid = 12'h305; e.rv = 1'b1; end
                        endcase
                    end else begin
                        case (s)
                            1: begin e.wen = 1'b1; e.wid = 12'h300; e.wdata = mret_status(mstatus);
                                     e.ren = 1'b1; e.rid = 12'h300; end
                            default: begin e.ren = 1'b1; e.rid = 12'h341; e.rv = 1'b1; end
                        endcase
                    end
                end
            end
            #1;
            check($sformatf("%s c%0d", tag, k), 64'(sample()), 64'(e));
            if (e.rv) check($sformatf("%s redirect_pc", tag), 64'(bus.o_redirect_pc), 64'(rpc));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        ld             = 1'b0;
        ld_mtvec       = 32'h0;
        ld_mepc        = 32'h0;
        ld_mstatus     = 32'h0;
        bus.i_ecall    = 1'b0;
        bus.i_mret     = 1'b0;
        bus.i_pc       = 32'h0;
        bus.i_cause    = 32'h0;
        bus.i_lsu_busy = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("reset", 64'(sample()), 64'h0);
        check("reset redirect_pc", 64'(bus.o_redirect_pc), 64'h0);

        // ecall with LSU idle
        run_txn("ecall", 1'b1, 1'b0, 32'h8000_0044, 32'd11, 32'h8000_0100,
                32'h0, 32'h0000_0008, 0, 1'b0, -1);
        check("ecall mepc", 64'(env_mepc), 64'h8000_0044);
        check("ecall mcause", 64'(env_mcause), 64'h0000_000B);
        check("ecall mstatus", 64'(env_mstatus), 64'h0000_1880);

        // mret
        run_txn("mret", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_0048,
                32'h0000_1880, 0, 1'b0, -1);
        check("mret mstatus", 64'(env_mstatus), 64'h0000_1888);

        // LSU busy for 4 cycles, below the timeout
        run_txn("drain4", 1'b1, 1'b0, 32'h8000_1003, 32'h8, 32'h8000_0200,
                32'h0, 32'h0000_0088, 4, 1'b0, -1);

        // LSU stuck busy: drain timeout
        run_txn("timeout", 1'b1, 1'b0, 32'h0000_4000, 32'h3, 32'h0000_0104,
                32'h0, 32'h0, 40, 1'b0, -1);
        run_txn("timeout_mret", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1234_5678,
                32'hFFFF_FFFF, TO, 1'b0, -1);

        // Simultaneous requests, and request noise mid-sequence
        run_txn("both", 1'b1, 1'b1, 32'h8000_0010, 32'd11, 32'h8000_0300,
                32'h0, 32'h0000_0008, 0, 1'b0, -1);
        run_txn("noise_ecall", 1'b1, 1'b0, 32'h8000_0020, 32'd9, 32'h8000_0400,
                32'h0, 32'h0, 2, 1'b1, -1);
        run_txn("noise_mret", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_0500,
                32'h0000_0080, 1, 1'b1, -1);

        // Reset asserted during W_CAUSE
        run_txn("rst_mid", 1'b1, 1'b0, 32'h8000_0060, 32'd11, 32'h8000_0100,
                32'h0, 32'h0000_0008, 0, 1'b0, 3);
        @(negedge clk);
        #1 check("rst_mid outputs", 64'(sample()), 64'h0);
        check("rst_mid mstatus kept", 64'(env_mstatus), 64'h0000_0008);
        check("rst_mid mcause written", 64'(env_mcause), 64'h0000_000B);

        // Randomized sequences
        for (int i = 0; i < 40; i++) begin
            run_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                    $urandom, $urandom, int'($urandom_range(0, TO + 2)),
                    1'($urandom_range(0, 1)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trap_seq.md
# trap_seq

Multi-cycle trap sequencer that owns the CSR write/read port during `ecall` and `mret`. On a trap request from IDU it:
- stalls the front end;
- waits for outstanding LSU bus transactions to drain;
- performs the architectural CSR updates one per cycle (mepc, mcause, mstatus);
- issues a single-cycle PC redirect to IFU.

It sits between IDU/LSU and the CSR controller. The CSR controller itself only does plain register reads and writes.

## Interface
Parameters:
- `DRAIN_TIMEOUT`, default 255: maximum number of cycles spent in DRAIN before forcing progress.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `i_ecall`  in  1  ecall request from IDU; sampled only in IDLE
- `i_mret`  in  1  mret request from IDU; sampled only in IDLE
- `i_pc`  in  32  PC of the trapping instruction; latched on accept
- `i_cause`  in  32  mcause value for ecall; latched on accept
- `i_lsu_busy`  in  1  high while an LSU bus transaction is outstanding
- `o_csr_wen`  out  1  CSR write enable
- `o_csr_wid`  out  12  CSR write address
- `o_csr_wdata`  out  32  CSR write data
- `o_csr_ren`  out  1  CSR read enable
- `o_csr_rid`  out  12  CSR read address
- `i_csr_rdata`  in  32  CSR read data; combinational, valid in the same cycle as ren/rid
- `o_redirect_valid`  out  1  one-cycle pulse; IFU loads `o_redirect_pc`
- `o_redirect_pc`  out  32  redirect target
- `o_stall`  out  1  front-end stall
- `o_busy`  out  1  high whenever state != IDLE
- `o_drain_err`  out  1  one-cycle pulse on drain timeout

## Operation
States: IDLE, DRAIN, W_EPC, W_CAUSE, W_STAT, REDIR. Encoding is free.

IDLE:
- If `i_ecall`: latch `kind=ECALL`, `pc=i_pc`, `cause=i_cause`; go to DRAIN.
- Else if `i_mret`: latch `kind=MRET`; go to DRAIN.
- If both are high, ecall wins.

DRAIN:
- An 8-bit counter is cleared on entry and increments each cycle `i_lsu_busy=1`.
- Leave when `i_lsu_busy=0`, or when the counter reaches `DRAIN_TIMEOUT`; on timeout, pulse `o_drain_err` in that cycle.
- Next state: W_EPC for ECALL, W_STAT for MRET.

W_EPC (ecall only):
- `wen=1`, `wid=12'h341`, `wdata={pc[31:2],2'b00}`.
- Next state: W_CAUSE.

W_CAUSE:
- `wen=1`, `wid=12'h342`, `wdata=cause`.
- Next state: W_STAT.

W_STAT:
- `ren=1`, `rid=12'h300`; `wen=1`, `wid=12'h300`, `wdata` is the read value with these fields modified:
  - ECALL: bit7 (MPIE) = rdata[3]; bit3 (MIE) = 0; bits[12:11] (MPP) = 2'b11.
  - MRET: bit3 = rdata[7]; bit7 = 1; bits[12:11] = 2'b11.
  - All other bits pass through unchanged.
- Next state: REDIR.

REDIR:
- `ren=1`, `rid` = `12'h305` (ECALL) or `12'h341` (MRET).
- `o_redirect_valid=1`, `o_redirect_pc={i_csr_rdata[31:2],2'b00}`.
- Next state: IDLE.

Outputs:
- `o_stall` = (state != IDLE) | (state == IDLE & (i_ecall | i_mret)). This is combinational, so IDU is held from the accept cycle onward.
- `i_ecall`/`i_mret` are ignored outside IDLE.
- All CSR port outputs are 0 (enables and data) in states where they are not driven.

## Timing
- Reset: state=IDLE; latched pc/cause/kind=0; counter=0.
- Every output is 0 during and after reset, until a request arrives. The one exception is `o_stall`, which may be high in a cycle where IDLE receives a request.
- Reset mid-sequence: return to IDLE next edge with no further writes. CSR writes already issued remain.
- Latency, no drain wait, cycle 0 = accept cycle:
  - ecall: DRAIN c1, W_EPC c2, W_CAUSE c3, W_STAT c4, REDIR c5; back in IDLE at c6, where a new request may be accepted.
  - mret: DRAIN c1, W_STAT c2, REDIR c3.
- Each cycle `i_lsu_busy` stays high in DRAIN adds one cycle, bounded by `DRAIN_TIMEOUT`.
- Exactly one CSR write per write state; never two writes in the same cycle.
- `o_redirect_valid` is exactly one cycle wide per accepted request.

## Test plan
- **ecall, LSU idle:** mtvec=0x80000100, mstatus=0x00000008, `i_pc`=0x80000044, `i_cause`=11.
  - Writes: 0x341←0x80000044 (c2), 0x342←0x0000000B (c3), 0x300←0x00001880 (c4).
  - Redirect to 0x80000100 at c5.
  - `o_stall` high c0–c5.
- **mret:** mepc=0x80000048, mstatus=0x00001880.
  - Write 0x300←0x00001888 (c2); redirect to 0x80000048 at c3.
- **Drain wait:** `i_lsu_busy` high 4 cycles after accept, then low.
  - W_EPC delayed by 4 cycles; no `o_drain_err`.
- **Drain timeout:** `DRAIN_TIMEOUT`=8, `i_lsu_busy` stuck high.
  - `o_drain_err` pulses once on the 8th DRAIN cycle; sequence then completes normally.
- **Request collisions:**
  - `i_ecall` and `i_mret` both high in IDLE: ecall sequence runs.
  - Extra `i_mret` pulses mid-sequence: ignored, no second redirect.
- **Reset mid-sequence:** `rst` asserted during W_CAUSE.
  - Next cycle: all outputs 0, state IDLE, no mstatus write, no redirect.
